// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: shared widths, register map and configuration record for the PWM DAC.
//   CNT_WIDTH_DEF / PRESC_WIDTH_DEF : default counter and prescaler widths
//   REG_* / CTRL_* / STATUS_*       : register byte offsets and bit positions
//   pwm_cfg_t                       : one full configuration set (staging and active copies)
package pwm_dac_pkg;

    localparam int CNT_WIDTH_DEF   = 16;
    localparam int PRESC_WIDTH_DEF = 8;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_PERIOD = 4'h4;
    localparam logic [3:0] REG_DUTY   = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_POL       = 1;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    localparam int STATUS_PENDING = 0;
    localparam int STATUS_RUNNING = 1;
    localparam int STATUS_CNT_LSB = 16;
    localparam int STATUS_CNT_MSB = 31;

    typedef struct packed {
        logic [PRESC_WIDTH_DEF-1:0] prescale;
        logic [CNT_WIDTH_DEF-1:0]   period;
        logic [CNT_WIDTH_DEF-1:0]   duty;
        logic                       polarity;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_dac_core_prescaler.sv
// pwm_prescaler: divides ACLK into a one-cycle tick every div+1 cycles.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   clr           : holds the divider at 0 and suppresses tick
//   div           : terminal count (0 = tick every cycle)
//   tick          : combinational, high in the last cycle of each division
module pwm_prescaler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   clr,
    input  logic [PRESC_WIDTH-1:0] div,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] presc_cnt;

    assign tick = !clr && (presc_cnt == div);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            presc_cnt <= '0;
        else
            presc_cnt <= (clr || tick) ? '0 : presc_cnt + PRESC_WIDTH'(1);
    end

endmodule

// File: rtl/pwm_dac_core.sv
// pwm_dac_core: double-buffered PWM generator driven by the PWM_DAC register slave.
//   ACLK, ARESETN        : clock, asynchronous active-low reset
//   cfg_enable           : run enable (registered into running)
//   cfg_polarity         : output inversion
//   cfg_prescale         : tick divider, one tick every cfg_prescale+1 cycles
//   cfg_period           : counter wraps after this value
//   cfg_duty             : active ticks per period
//   cfg_load             : capture cfg_* into the staging registers
//   cfg_pending          : staged values not yet applied
//   pwm_out              : registered PWM output
//   period_tick          : one-cycle pulse after each counter wrap
//   cnt_value            : live main counter
//   running              : registered cfg_enable
module pwm_dac_core
    import pwm_dac_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   cfg_enable,
    input  logic                   cfg_polarity,
    input  logic [PRESC_WIDTH-1:0] cfg_prescale,
    input  logic [CNT_WIDTH-1:0]   cfg_period,
    input  logic [CNT_WIDTH-1:0]   cfg_duty,
    input  logic                   cfg_load,
    output logic                   cfg_pending,
    output logic                   pwm_out,
    output logic                   period_tick,
    output logic [CNT_WIDTH-1:0]   cnt_value,
    output logic                   running
);

    pwm_cfg_t             stage;
    pwm_cfg_t             act;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 tick;
    logic                 wrap;
    logic                 apply;

    pwm_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr     (!running),
        .div     (act.prescale),
        .tick    (tick)
    );

    // Staging only differs from active while pending is set, so applying
    // unconditionally when idle is harmless and keeps the update path simple.
    always_comb begin
        wrap  = tick && (cnt == act.period);
        apply = wrap || !running;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            running     <= 1'b0;
            stage       <= '0;
            act         <= '0;
            cfg_pending <= 1'b0;
            cnt         <= '0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            running     <= cfg_enable;
            if (cfg_load)
                stage <= {cfg_prescale, cfg_period, cfg_duty, cfg_polarity};
            // A load coinciding with a wrap still applies the old staging;
            // the new values wait for the next boundary.
            if (apply)
                act <= stage;
            cfg_pending <= cfg_load || (cfg_pending && !apply);
            cnt         <= (!running || wrap) ? '0 : cnt + CNT_WIDTH'(tick);
            period_tick <= wrap;
            pwm_out     <= running ? ((cnt < act.duty) ^ act.polarity) : act.polarity;
        end
    end

    assign cnt_value = cnt;

endmodule

// File: tb/tb_pwm_dac_core.sv
// tb_pwm_dac_core: directed and randomized checks of pwm_dac_core against a period-position model.
module tb_pwm_dac_core;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        cfg_polarity = 1'b0;
    logic [7:0]  cfg_prescale = '0;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_duty = '0;
    logic        cfg_load = 1'b0;
    logic        cfg_pending;
    logic        pwm_out;
    logic        period_tick;
    logic [15:0] cnt_value;
    logic        running;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;

    // Model: position m_t in cycles since the start of the current period.
    bit          m_run, m_pend, m_pwm, m_tick;
    int unsigned m_t;
    int unsigned s_pre, s_per, s_duty, a_pre, a_per, a_duty;
    bit          s_pol, a_pol;

    always #5 ACLK = ~ACLK;

    pwm_dac_core dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_enable   (cfg_enable),
        .cfg_polarity (cfg_polarity),
        .cfg_prescale (cfg_prescale),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_load     (cfg_load),
        .cfg_pending  (cfg_pending),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick),
        .cnt_value    (cnt_value),
        .running      (running)
    );

    assign obs = {pwm_out, period_tick, cfg_pending, running, cnt_value};

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_pwm = 0; m_tick = 0; m_t = 0;
        s_pre = 0; s_per = 0; s_duty = 0; s_pol = 0;
        a_pre = 0; a_per = 0; a_duty = 0; a_pol = 0;
    endfunction

    function automatic void model_step();
        int unsigned len;
        bit wrap, apply;
        len    = (a_per + 1) * (a_pre + 1);
        wrap   = m_run && (m_t == len - 1);
        m_pwm  = m_run ? (((m_t / (a_pre + 1)) < a_duty) ^ a_pol) : a_pol;
        m_tick = wrap;
        m_t    = (!m_run || wrap) ? 0 : m_t + 1;
        apply  = wrap || !m_run;
        if (apply) begin
            a_pre = s_pre; a_per = s_per; a_duty = s_duty; a_pol = s_pol;
        end
        if (cfg_load) begin
            s_pre = cfg_prescale; s_per = cfg_period; s_duty = cfg_duty; s_pol = cfg_polarity;
        end
        m_pend = cfg_load || (m_pend && !apply);
        m_run  = cfg_enable;
    endfunction

    function automatic logic [19:0] exp_vec();
        return {m_pwm, m_tick, m_pend, m_run, 16'(m_t / (a_pre + 1))};
    endfunction

    function automatic bit wrap_now();
        return m_run && (m_t == (a_per + 1) * (a_pre + 1) - 1);
    endfunction

    task automatic cyc();
        @(posedge ACLK);
        if (!ARESETN) model_reset(); else model_step();
        @(negedge ACLK);
    endtask

    task automatic load(input int pre, input int per, input int duty, input bit pol);
        cfg_prescale = 8'(pre); cfg_period = 16'(per); cfg_duty = 16'(duty); cfg_polarity = pol;
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        #2 ARESETN = 1'b0;
        #1;
        model_reset();
        checks++; if (obs !== 20'h0) begin errors++; $display("FAIL reset_async obs=%h exp=%h", obs, 20'h0); end
        @(negedge ACLK);
        cfg_prescale = 8'd3; cfg_period = 16'd7; cfg_duty = 16'd2; cfg_load = 1'b1;
        repeat (20) cyc();
        checks++; if (obs !== 20'h0) begin errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, 20'h0); end
        cfg_load = 1'b0;
        ARESETN = 1'b1;
        cyc();
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_load_ignored pending=%b exp=0", cfg_pending); end
        checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL reset_release obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_basic();
        int hi = 0, tk = 0;
        load(0, 9, 3, 0);
        cfg_enable = 1'b1;
        repeat (5) begin
            cyc();
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL basic_start t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        repeat (20) begin
            cyc();
            hi += int'(pwm_out); tk += int'(period_tick);
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL basic_cycle t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        checks++; if (hi !== 6) begin errors++; $display("FAIL basic_high high=%0d exp=6", hi); end
        checks++; if (tk !== 2) begin errors++; $display("FAIL basic_ticks ticks=%0d exp=2", tk); end
    endtask

    task automatic test_update();
        int n = 0, hi = 0;
        while (cnt_value != 16'd4 && n < 40) begin
            cyc(); n++;
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL update_wait t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        checks++; if (cnt_value !== 16'd4) begin errors++; $display("FAIL update_timeout cnt=%0d exp=4", cnt_value); end
        load(0, 9, 7, 0);
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL update_pending pending=%b exp=1", cfg_pending); end
        n = 0;
        while (period_tick !== 1'b1 && n < 20) begin
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL update_old t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
            cyc(); n++;
        end
        checks++; if (period_tick !== 1'b1 || cfg_pending !== 1'b0) begin errors++; $display("FAIL update_apply tick=%b pending=%b exp=1/0", period_tick, cfg_pending); end
        repeat (20) begin
            cyc();
            hi += int'(pwm_out);
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL update_new t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        checks++; if (hi !== 14) begin errors++; $display("FAIL update_high high=%0d exp=14", hi); end
    endtask

    task automatic test_extremes();
        int duty_t[3] = '{0, 10, 3};
        bit pol_t[3]  = '{0, 0, 1};
        int hi_t[3]   = '{0, 20, 14};
        for (int i = 0; i < 3; i++) begin
            int hi = 0;
            load(0, 9, duty_t[i], pol_t[i]);
            repeat (45) begin
                cyc();
                hi += int'(pwm_out);
                checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL extreme%0d_cycle t=%0t obs=%h exp=%h", i, $time, obs, exp_vec()); end
            end
            hi = 0;
            repeat (20) begin
                cyc();
                hi += int'(pwm_out);
            end
            checks++; if (hi !== hi_t[i]) begin errors++; $display("FAIL extreme%0d_high high=%0d exp=%0d", i, hi, hi_t[i]); end
        end
    endtask

    task automatic test_prescale_wrap();
        int hi = 0, tk = 0, n = 0;
        load(1, 4, 2, 0);
        repeat (25) begin
            cyc();
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL presc_settle t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        repeat (20) begin
            cyc();
            hi += int'(pwm_out); tk += int'(period_tick);
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL presc_cycle t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        checks++; if (hi !== 8 || tk !== 2) begin errors++; $display("FAIL presc_shape high=%0d ticks=%0d exp=8/2", hi, tk); end
        while (!wrap_now() && n < 20) begin cyc(); n++; end
        checks++; if (!wrap_now()) begin errors++; $display("FAIL presc_wrap_timeout cnt=%0d", cnt_value); end
        load(1, 4, 4, 0);
        checks++; if (period_tick !== 1'b1 || cfg_pending !== 1'b1) begin errors++; $display("FAIL load_at_wrap tick=%b pending=%b exp=1/1", period_tick, cfg_pending); end
        repeat (10) begin
            cyc();
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL load_wrap_cycle t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        checks++; if (period_tick !== 1'b1 || cfg_pending !== 1'b0) begin errors++; $display("FAIL load_wrap_apply tick=%b pending=%b exp=1/0", period_tick, cfg_pending); end
        hi = 0;
        repeat (20) begin cyc(); hi += int'(pwm_out); end
        checks++; if (hi !== 16) begin errors++; $display("FAIL load_wrap_high high=%0d exp=16", hi); end
    endtask

    task automatic test_abort();
        int n = 0, hi = 0;
        load(0, 9, 3, 0);
        repeat (25) cyc();
        while (cnt_value != 16'd5 && n < 20) begin cyc(); n++; end
        checks++; if (cnt_value !== 16'd5) begin errors++; $display("FAIL abort_timeout cnt=%0d exp=5", cnt_value); end
        cfg_enable = 1'b0;
        load(0, 9, 6, 0);
        cyc();
        checks++; if ({pwm_out, cnt_value, cfg_pending, running} !== 19'h0) begin errors++; $display("FAIL abort_stop pwm=%b cnt=%0d pending=%b run=%b exp=0", pwm_out, cnt_value, cfg_pending, running); end
        checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL abort_model obs=%h exp=%h", obs, exp_vec()); end
        repeat (3) cyc();
        cfg_enable = 1'b1;
        repeat (5) begin
            cyc();
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL restart_cycle t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        repeat (20) begin cyc(); hi += int'(pwm_out); end
        checks++; if (hi !== 12) begin errors++; $display("FAIL restart_high high=%0d exp=12", hi); end
        repeat (3) cyc();
        #2 ARESETN = 1'b0;
        #1;
        model_reset();
        checks++; if (obs !== 20'h0) begin errors++; $display("FAIL abort_reset obs=%h exp=%h", obs, 20'h0); end
        cyc();
        ARESETN = 1'b1;
        repeat (4) begin
            cyc();
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL post_reset t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        repeat (800) begin
            if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
            cfg_load = ($urandom_range(0, 9) == 0);
            if (cfg_load) begin
                cfg_prescale = 8'($urandom_range(0, 3));
                cfg_period   = 16'($urandom_range(0, 12));
                cfg_duty     = 16'($urandom_range(0, 14));
                cfg_polarity = 1'($urandom_range(0, 1));
            end
            cyc();
            checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL random t=%0t obs=%h exp=%h", $time, obs, exp_vec()); end
        end
        cfg_load = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_update();
        test_extremes();
        test_prescale_wrap();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
